// File: rtl/clk_sel_pkg.sv
// Shared types and constants for the divided-clock selector.
// Holds the switch FSM state encoding, selection codes and the edge-detect helper.
package clk_sel_pkg;

    typedef enum logic [1:0] {
        RUN          = 2'd0,
        WAIT_OLD_LOW = 2'd1,
        WAIT_NEW_LOW = 2'd2
    } state_t;

    localparam logic [1:0] SEL_DIV2  = 2'd0;
    localparam logic [1:0] SEL_DIV4  = 2'd1;
    localparam logic [1:0] SEL_DIV8  = 2'd2;
    localparam logic [1:0] SEL_DIV16 = 2'd3;

    // Rising edge of one divided level, judged against last cycle's sample.
    function automatic logic rise_at(input logic [3:0] now_v,
                                     input logic [3:0] prev_v,
                                     input logic [1:0] idx);
        return now_v[idx] & ~prev_v[idx];
    endfunction

endpackage

// File: rtl/clk_sel_tick_if.sv
// Selection request handshake between a requester and clk_sel_tick.
interface clk_sel_tick_if;
    logic [1:0] sel;
    logic       sel_valid;
    logic       sel_ready;

    modport master (output sel, output sel_valid, input sel_ready);
    modport slave  (input sel, input sel_valid, output sel_ready);
endinterface

// File: rtl/clk_tick_counter.sv
// Wrapping event counter advanced by a one-cycle enable.
module clk_tick_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    output logic [CNT_W-1:0] count
);
    logic [CNT_W-1:0] count_r;

    // Count register: clears on reset, wraps naturally on overflow.
    always_ff @(posedge clk) begin
        if (!rst) begin
            count_r <= {CNT_W{1'b0}};
        end else if (en) begin
            count_r <= count_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            count_r <= count_r;
        end
    end

    assign count = count_r;
endmodule

// File: rtl/clk_sel_tick.sv
// Glitch-free runtime selector over the registered div2/4/8/16 levels with a tick strobe.
// Define CLK_SEL_TICK_COUNT_EN to build the tick counter behind tick_count.
module clk_sel_tick #(
    parameter int         CNT_W     = 16,
    parameter logic [1:0] SEL_RESET = 2'd0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       div_in,
    clk_sel_tick_if.slave    req,
    output logic             clk_out,
    output logic             tick,
    output logic             busy,
    output logic [CNT_W-1:0] tick_count
);
    import clk_sel_pkg::*;

    state_t     state_r, state_next_s;
    logic [1:0] cur_r, cur_next_s;
    logic [1:0] nxt_r, nxt_next_s;
    logic [3:0] prev_r;
    logic       clk_out_r, clk_out_next_s;
    logic       tick_r, tick_next_s;
    logic       busy_r, sel_ready_r;

    // Next-state and output decode; the new source is only exposed after both
    // the old and the new level have been seen low, so no runt high phase can form.
    always_comb begin
        state_next_s   = state_r;
        cur_next_s     = cur_r;
        nxt_next_s     = nxt_r;
        clk_out_next_s = 1'b0;
        tick_next_s    = 1'b0;
        case (state_r)
            RUN: begin
                clk_out_next_s = div_in[cur_r];
                tick_next_s    = rise_at(div_in, prev_r, cur_r);
                if (req.sel_valid && sel_ready_r && (req.sel != cur_r)) begin
                    nxt_next_s   = req.sel;
                    state_next_s = WAIT_OLD_LOW;
                end else begin
                    state_next_s = RUN;
                end
            end
            WAIT_OLD_LOW: begin
                clk_out_next_s = div_in[cur_r];
                tick_next_s    = rise_at(div_in, prev_r, cur_r);
                if (!div_in[cur_r]) begin
                    cur_next_s   = nxt_r;
                    state_next_s = WAIT_NEW_LOW;
                end else begin
                    state_next_s = WAIT_OLD_LOW;
                end
            end
            WAIT_NEW_LOW: begin
                if (!div_in[cur_r]) begin
                    state_next_s = RUN;
                end else begin
                    state_next_s = WAIT_NEW_LOW;
                end
            end
            default: begin
                state_next_s = RUN;
            end
        endcase
    end

    // State, selection, edge history and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r     <= RUN;
            cur_r       <= SEL_RESET;
            nxt_r       <= SEL_RESET;
            prev_r      <= 4'b0000;
            clk_out_r   <= 1'b0;
            tick_r      <= 1'b0;
            busy_r      <= 1'b0;
            sel_ready_r <= 1'b1;
        end else begin
            state_r     <= state_next_s;
            cur_r       <= cur_next_s;
            nxt_r       <= nxt_next_s;
            prev_r      <= div_in;
            clk_out_r   <= clk_out_next_s;
            tick_r      <= tick_next_s;
            busy_r      <= (state_next_s != RUN);
            sel_ready_r <= (state_next_s == RUN);
        end
    end

    assign clk_out       = clk_out_r;
    assign tick          = tick_r;
    assign busy          = busy_r;
    assign req.sel_ready = sel_ready_r;

`ifdef CLK_SEL_TICK_COUNT_EN
    clk_tick_counter #(.CNT_W(CNT_W)) u_tick_counter (
        .clk   (clk),
        .rst   (rst),
        .en    (tick_next_s),
        .count (tick_count)
    );
`else
    assign tick_count = {CNT_W{1'b0}};
`endif

endmodule
